// File: rtl/pgm_pkg.sv
// Shared types and sizes for the PGM RAM arbiter slice.
package pgm_pkg;
  localparam int PGM_ADDR_W = 7;
  localparam int PGM_DATA_W = 144;
  localparam int PGM_DEPTH  = 128;

  typedef enum logic [1:0] {
    GNT_NONE = 2'd0,
    GNT_RD   = 2'd1,
    GNT_WR   = 2'd2
  } grant_t;
endpackage

// File: rtl/pgm_arb_rr.sv
// Two-way PGM RAM arbiter: round-robin outside the send window, read priority
// with a write starvation guard inside it.
module pgm_arb_rr
  import pgm_pkg::*;
#(
  parameter int STARVE_MAX = 16
) (
  input  logic   clk,
  input  logic   rst_n,
  input  logic   wr_req,
  input  logic   rd_req,
  input  logic   win_open,
  output grant_t gnt
);

  logic       pref_rd_q, pref_rd_d;
  logic [7:0] starve_q, starve_d;
  logic       starved;

  assign starved = (starve_q == 8'(STARVE_MAX));

  always_comb begin
    gnt = GNT_NONE;
    if (rst_n) begin
      if (wr_req && rd_req) begin
        if (win_open) gnt = starved ? GNT_WR : GNT_RD;
        else          gnt = pref_rd_q ? GNT_RD : GNT_WR;
      end else if (wr_req) begin
        gnt = GNT_WR;
      end else if (rd_req) begin
        gnt = GNT_RD;
      end
    end
  end

  // Pointer moves only on contested grants; the starvation count only
  // advances while the window is open and holds its value otherwise.
  always_comb begin
    pref_rd_d = pref_rd_q;
    if (wr_req && rd_req) pref_rd_d = (gnt == GNT_WR);
    starve_d = starve_q;
    if (!wr_req || gnt == GNT_WR) starve_d = '0;
    else if (win_open && !starved) starve_d = starve_q + 8'd1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pref_rd_q <= 1'b1;
      starve_q  <= '0;
    end else begin
      pref_rd_q <= pref_rd_d;
      starve_q  <= starve_d;
    end
  end

endmodule

// File: rtl/pgm_ram_arb.sv
// Shares the single-port PGM RAM between the cfg write path and pgm_rd fetch;
// holds the send-window flag, read-valid pipe and conflict counter.
module pgm_ram_arb
  import pgm_pkg::*;
#(
  parameter int ADDR_W     = PGM_ADDR_W,
  parameter int DATA_W     = PGM_DATA_W,
  parameter int STARVE_MAX = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr2arb_req,
  input  logic [ADDR_W-1:0] wr2arb_addr,
  input  logic [DATA_W-1:0] wr2arb_wdata,
  output logic              arb2wr_ack,
  input  logic              rd2ram_rd,
  input  logic [ADDR_W-1:0] rd2ram_addr,
  output logic              arb2rd_ack,
  output logic [DATA_W-1:0] ram2rd_rdata,
  output logic              ram2rd_rdata_valid,
  input  logic              pgm_sent_start_flag,
  input  logic              pgm_sent_finish_flag,
  output logic              arb2ram_en,
  output logic              arb2ram_we,
  output logic [ADDR_W-1:0] arb2ram_addr,
  output logic [DATA_W-1:0] arb2ram_wdata,
  input  logic [DATA_W-1:0] ram2arb_rdata,
  input  logic              cnt_clr,
  output logic [15:0]       conflict_cnt
);

  grant_t            gnt;
  logic              win_q, win_d;
  logic              rvld_q, rvld_d;
  logic [15:0]       cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;

  pgm_arb_rr #(
    .STARVE_MAX(STARVE_MAX)
  ) u_arb (
    .clk      (clk),
    .rst_n    (rst_n),
    .wr_req   (wr2arb_req),
    .rd_req   (rd2ram_rd),
    .win_open (win_q),
    .gnt      (gnt)
  );

  always_comb begin
    win_d = win_q;
    if (pgm_sent_finish_flag)     win_d = 1'b0;
    else if (pgm_sent_start_flag) win_d = 1'b1;

    rvld_d = (gnt == GNT_RD);

    cnt_d = cnt_q;
    if (cnt_clr) cnt_d = '0;
    else if (wr2arb_req && rd2ram_rd && cnt_q != 16'hFFFF) cnt_d = cnt_q + 16'd1;

    // Idle cycles keep the last address/data on the RAM bus.
    addr_d  = addr_q;
    wdata_d = wdata_q;
    case (gnt)
      GNT_WR: begin
        addr_d  = wr2arb_addr;
        wdata_d = wr2arb_wdata;
      end
      GNT_RD:  addr_d = rd2ram_addr;
      default: ;
    endcase
  end

  // Everything is forced low while rst_n=0, including an in-flight read-valid.
  assign arb2ram_en         = (gnt != GNT_NONE);
  assign arb2ram_we         = (gnt == GNT_WR);
  assign arb2wr_ack         = (gnt == GNT_WR);
  assign arb2rd_ack         = (gnt == GNT_RD);
  assign arb2ram_addr       = rst_n ? addr_d  : '0;
  assign arb2ram_wdata      = rst_n ? wdata_d : '0;
  assign ram2rd_rdata_valid = rvld_q & rst_n;
  assign ram2rd_rdata       = ram2rd_rdata_valid ? ram2arb_rdata : '0;
  assign conflict_cnt       = rst_n ? cnt_q : '0;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      win_q   <= 1'b0;
      rvld_q  <= 1'b0;
      cnt_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      win_q   <= win_d;
      rvld_q  <= rvld_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  end

endmodule

// File: tb/tb_pgm_ram_arb.sv
// Directed bench for pgm_ram_arb with a behavioural RAM and a read-data scoreboard.
module tb_pgm_ram_arb;
  import pgm_pkg::*;

  localparam int AW = 7;
  localparam int DW = 144;
  localparam int SM = 16;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          wr2arb_req;
  logic [AW-1:0] wr2arb_addr;
  logic [DW-1:0] wr2arb_wdata;
  logic          arb2wr_ack;
  logic          rd2ram_rd;
  logic [AW-1:0] rd2ram_addr;
  logic          arb2rd_ack;
  logic [DW-1:0] ram2rd_rdata;
  logic          ram2rd_rdata_valid;
  logic          pgm_sent_start_flag;
  logic          pgm_sent_finish_flag;
  logic          arb2ram_en;
  logic          arb2ram_we;
  logic [AW-1:0] arb2ram_addr;
  logic [DW-1:0] arb2ram_wdata;
  logic [DW-1:0] ram2arb_rdata;
  logic          cnt_clr;
  logic [15:0]   conflict_cnt;

  always #5 clk = ~clk;

  pgm_ram_arb #(.ADDR_W(AW), .DATA_W(DW), .STARVE_MAX(SM)) dut (
    .clk                  (clk),
    .rst_n                (rst_n),
    .wr2arb_req           (wr2arb_req),
    .wr2arb_addr          (wr2arb_addr),
    .wr2arb_wdata         (wr2arb_wdata),
    .arb2wr_ack           (arb2wr_ack),
    .rd2ram_rd            (rd2ram_rd),
    .rd2ram_addr          (rd2ram_addr),
    .arb2rd_ack           (arb2rd_ack),
    .ram2rd_rdata         (ram2rd_rdata),
    .ram2rd_rdata_valid   (ram2rd_rdata_valid),
    .pgm_sent_start_flag  (pgm_sent_start_flag),
    .pgm_sent_finish_flag (pgm_sent_finish_flag),
    .arb2ram_en           (arb2ram_en),
    .arb2ram_we           (arb2ram_we),
    .arb2ram_addr         (arb2ram_addr),
    .arb2ram_wdata        (arb2ram_wdata),
    .ram2arb_rdata        (ram2arb_rdata),
    .cnt_clr              (cnt_clr),
    .conflict_cnt         (conflict_cnt)
  );

  function automatic logic [DW-1:0] pat(input int i);
    logic [7:0] b;
    b = 8'(i) ^ 8'h3C;
    return {18{b}};
  endfunction

  // Registered single-port RAM, preloaded while ram_init is high.
  logic          ram_init;
  logic [DW-1:0] ram_mem [PGM_DEPTH];
  logic [DW-1:0] ram_q;
  always @(posedge clk) begin
    if (ram_init) begin
      for (int i = 0; i < PGM_DEPTH; i++) ram_mem[i] <= pat(i);
      ram_q <= '0;
    end else if (arb2ram_en) begin
      if (arb2ram_we) ram_mem[arb2ram_addr] <= arb2ram_wdata;
      else            ram_q <= ram_mem[arb2ram_addr];
    end
  end
  assign ram2arb_rdata = ram_q;

  logic [DW-1:0] smem [PGM_DEPTH];
  logic [DW-1:0] exp_q [$];
  logic          last_rd;
  int            compared;
  int            mismatched;

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: check the grant expected for the current inputs and the
  // read-valid owed by the previous cycle, then advance.
  task automatic step(input grant_t eg);
    logic [DW-1:0] e;
    @(negedge clk);
    chk("wr_ack", {{(DW-1){1'b0}}, arb2wr_ack}, {{(DW-1){1'b0}}, eg == GNT_WR});
    chk("rd_ack", {{(DW-1){1'b0}}, arb2rd_ack}, {{(DW-1){1'b0}}, eg == GNT_RD});
    chk("ram_en", {{(DW-1){1'b0}}, arb2ram_en}, {{(DW-1){1'b0}}, eg != GNT_NONE});
    chk("ram_we", {{(DW-1){1'b0}}, arb2ram_we}, {{(DW-1){1'b0}}, eg == GNT_WR});
    if (last_rd && rst_n) begin
      chk("rvalid", {{(DW-1){1'b0}}, ram2rd_rdata_valid}, {{(DW-1){1'b0}}, 1'b1});
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("rdata", ram2rd_rdata, e);
      end else begin
        chk("rdata_queue_empty", {{(DW-1){1'b0}}, 1'b1}, {{(DW-1){1'b0}}, 1'b0} | {{(DW-1){1'b0}}, ram2rd_rdata_valid ^ 1'b1});
      end
    end else begin
      chk("rvalid_idle", {{(DW-1){1'b0}}, ram2rd_rdata_valid}, '0);
      if (last_rd && exp_q.size() > 0) void'(exp_q.pop_front());
    end
    if (eg == GNT_RD) begin
      chk("rd_addr", {{(DW-AW){1'b0}}, arb2ram_addr}, {{(DW-AW){1'b0}}, rd2ram_addr});
      exp_q.push_back(smem[rd2ram_addr]);
    end
    if (eg == GNT_WR) begin
      chk("wr_addr", {{(DW-AW){1'b0}}, arb2ram_addr}, {{(DW-AW){1'b0}}, wr2arb_addr});
      chk("wr_data", arb2ram_wdata, wr2arb_wdata);
      smem[wr2arb_addr] = wr2arb_wdata;
    end
    last_rd = (eg == GNT_RD);
    @(posedge clk);
    #1;
  endtask

  task automatic chk_cnt(input string tag, input logic [15:0] exp);
    chk(tag, {{(DW-16){1'b0}}, conflict_cnt}, {{(DW-16){1'b0}}, exp});
  endtask

  initial begin
    compared   = 0;
    mismatched = 0;
    last_rd    = 1'b0;
    for (int i = 0; i < PGM_DEPTH; i++) smem[i] = pat(i);
    ram_init             = 1'b1;
    rst_n                = 1'b0;
    wr2arb_req           = 1'b1;
    wr2arb_addr          = 7'h01;
    wr2arb_wdata         = '1;
    rd2ram_rd            = 1'b1;
    rd2ram_addr          = 7'h02;
    pgm_sent_start_flag  = 1'b0;
    pgm_sent_finish_flag = 1'b0;
    cnt_clr              = 1'b0;

    // Reset with requests asserted: nothing granted, outputs zero.
    step(GNT_NONE);
    ram_init = 1'b0;
    chk("reset_wdata", arb2ram_wdata, '0);
    step(GNT_NONE);
    chk_cnt("reset_cnt", 16'h0);
    rst_n = 1'b1;
    wr2arb_req = 1'b0;
    rd2ram_rd  = 1'b0;
    step(GNT_NONE);

    // Lone write then read-back of the same word.
    wr2arb_req = 1'b1; wr2arb_addr = 7'h05; wr2arb_wdata = {18{8'hA5}};
    step(GNT_WR);
    wr2arb_req = 1'b0;
    rd2ram_rd = 1'b1; rd2ram_addr = 7'h05;
    step(GNT_RD);
    rd2ram_rd = 1'b0;
    step(GNT_NONE);

    // Window closed, both held: strict alternation starting with read.
    wr2arb_req = 1'b1; wr2arb_addr = 7'h20; wr2arb_wdata = {18{8'h11}};
    rd2ram_rd = 1'b1; rd2ram_addr = 7'h21;
    step(GNT_RD); step(GNT_WR); step(GNT_RD);
    step(GNT_WR); step(GNT_RD); step(GNT_WR);
    wr2arb_req = 1'b0; rd2ram_rd = 1'b0;
    step(GNT_NONE);
    chk_cnt("cnt_after_rr", 16'd6);

    // Send window: reads win until the write has waited STARVE_MAX cycles.
    pgm_sent_start_flag = 1'b1;
    step(GNT_NONE);
    pgm_sent_start_flag = 1'b0;
    wr2arb_req = 1'b1; wr2arb_addr = 7'h30; wr2arb_wdata = {18{8'h33}};
    rd2ram_rd = 1'b1; rd2ram_addr = 7'h30;
    for (int i = 0; i < SM; i++) step(GNT_RD);
    step(GNT_WR);
    for (int i = 0; i < 3; i++) step(GNT_RD);
    wr2arb_req = 1'b0; rd2ram_rd = 1'b0;
    pgm_sent_finish_flag = 1'b1;
    step(GNT_NONE);
    pgm_sent_finish_flag = 1'b0;
    // Last contested grant was a read, so round-robin now favours the write.
    wr2arb_req = 1'b1; rd2ram_rd = 1'b1;
    step(GNT_WR);
    step(GNT_RD);
    wr2arb_req = 1'b0; rd2ram_rd = 1'b0;
    step(GNT_NONE);

    // start and finish together leave the window closed.
    pgm_sent_start_flag = 1'b1; pgm_sent_finish_flag = 1'b1;
    step(GNT_NONE);
    pgm_sent_start_flag = 1'b0; pgm_sent_finish_flag = 1'b0;
    wr2arb_req = 1'b1; rd2ram_rd = 1'b1;
    step(GNT_WR);
    wr2arb_req = 1'b0; rd2ram_rd = 1'b0;
    step(GNT_NONE);

    // Same address, read favoured: first read sees old data, next sees new.
    wr2arb_req = 1'b1; wr2arb_addr = 7'h10; wr2arb_wdata = {18{8'h5A}};
    rd2ram_rd = 1'b1; rd2ram_addr = 7'h10;
    step(GNT_RD);
    rd2ram_rd = 1'b0;
    step(GNT_WR);
    wr2arb_req = 1'b0;
    rd2ram_rd = 1'b1;
    step(GNT_RD);
    rd2ram_rd = 1'b0;
    step(GNT_NONE);

    // Reset right after a read grant drops the pending valid.
    rd2ram_rd = 1'b1; rd2ram_addr = 7'h21;
    step(GNT_RD);
    rd2ram_rd = 1'b0;
    rst_n = 1'b0;
    step(GNT_NONE);
    chk_cnt("cnt_in_reset", 16'h0);
    wr2arb_req = 1'b1; wr2arb_addr = 7'h22; wr2arb_wdata = {18{8'h77}};
    rd2ram_rd = 1'b1; rd2ram_addr = 7'h23;
    step(GNT_NONE);
    step(GNT_NONE);
    rst_n = 1'b1;
    step(GNT_RD);
    step(GNT_WR);
    wr2arb_req = 1'b0; rd2ram_rd = 1'b0;
    step(GNT_NONE);
    chk_cnt("cnt_after_reset", 16'd2);

    // Saturate the conflict counter, then clear it while still contested.
    cnt_clr = 1'b1;
    step(GNT_NONE);
    cnt_clr = 1'b0;
    chk_cnt("cnt_clr_idle", 16'h0);
    wr2arb_req = 1'b1; wr2arb_addr = 7'h40; wr2arb_wdata = {18{8'hC3}};
    rd2ram_rd = 1'b1; rd2ram_addr = 7'h41;
    repeat (65540) @(posedge clk);
    #1;
    chk_cnt("cnt_saturated", 16'hFFFF);
    repeat (2) @(posedge clk);
    #1;
    chk_cnt("cnt_held_sat", 16'hFFFF);
    cnt_clr = 1'b1;
    @(posedge clk); #1;
    cnt_clr = 1'b0;
    chk_cnt("cnt_clr_wins", 16'h0);
    @(posedge clk); #1;
    chk_cnt("cnt_restart", 16'd1);
    wr2arb_req = 1'b0; rd2ram_rd = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    last_rd = 1'b0;
    exp_q.delete();
    smem[7'h40] = {18{8'hC3}};

    rd2ram_rd = 1'b1; rd2ram_addr = 7'h40;
    step(GNT_RD);
    rd2ram_rd = 1'b0;
    step(GNT_NONE);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/pgm_ram_arb.md
Name: pgm_ram_arb

Overview:
- Shares the single-port 128x144 PGM RAM between two requesters: the configuration write path (program loads from DMA cfg packets) and the pgm_rd read path (program fetch during packet generation).
- Grants at most one RAM access per cycle.
- Returns read data with a valid strobe.
- Prioritises reads while a program send is in progress, with a starvation guard so the write path always makes progress.

Parameters:
- ADDR_W, 7, RAM address width (depth 2^ADDR_W = 128)
- DATA_W, 144, RAM word width
- STARVE_MAX, 16, max consecutive cycles a pending write may be denied inside a send window (range 1..255)

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset; synchronous, active-low
- wr2arb_req  in  1  write request, level, held until ack
- wr2arb_addr  in  ADDR_W  write address
- wr2arb_wdata  in  DATA_W  write data
- arb2wr_ack  out  1  one-cycle pulse: write performed this cycle
- rd2ram_rd  in  1  read request from pgm_rd, level, held until ack
- rd2ram_addr  in  ADDR_W  read address
- arb2rd_ack  out  1  one-cycle pulse: read issued this cycle
- ram2rd_rdata  out  DATA_W  read data to pgm_rd
- ram2rd_rdata_valid  out  1  ram2rd_rdata valid this cycle
- pgm_sent_start_flag  in  1  pulse: send window opens
- pgm_sent_finish_flag  in  1  pulse: send window closes
- arb2ram_en  out  1  RAM enable
- arb2ram_we  out  1  RAM write enable
- arb2ram_addr  out  ADDR_W  RAM address
- arb2ram_wdata  out  DATA_W  RAM write data
- ram2arb_rdata  in  DATA_W  RAM read data, registered, valid 1 cycle after en with we=0
- cnt_clr  in  1  clear conflict counter
- conflict_cnt  out  16  cycles with both requests pending, saturating

Behaviour:
- Reset (rst_n=0 at posedge):
  - All outputs 0; send window closed.
  - RR pointer set so the next contested grant goes to read.
  - Starvation counter 0; any in-flight read-valid dropped.
  - Requests are ignored while rst_n=0.
- Grant decision is combinational from current requests and registered state.
  - RAM-side outputs and acks are driven in the grant cycle N: en=1; we/addr/wdata muxed from the winner; ack to the winner.
  - With no request: en=0, we=0, addr/wdata hold their last value.
- Read latency: ram2rd_rdata = ram2arb_rdata; ram2rd_rdata_valid=1 in cycle N+1 only, for a read granted in N.
- Requesters must keep req/addr/wdata stable until ack. A requester may re-request in the cycle after its ack, or keep req high for back-to-back access.
- Send window register:
  - start=1, finish=0 sets it.
  - finish=1 clears it; finish wins when both are 1.
  - The window takes effect from the next cycle.
- Arbitration, window closed (round-robin):
  - Single request is granted immediately.
  - Both pending: grant the side not granted at the last contested grant; pointer updates only on contested grants.
- Arbitration, window open (read strict priority):
  - The starvation counter increments each cycle a write is pending and denied. It resets to 0 on any write grant or when wr2arb_req=0.
  - When the counter equals STARVE_MAX, the write wins that cycle even if a read is pending. The read is delayed one cycle.
- Window transition: the starvation counter keeps its value across open/close. It is only meaningful inside the window.
- Same-address read/write pending together: there is no forwarding. Grant order defines the result: a read granted after the write returns new data, one granted before returns old data.
- conflict_cnt:
  - +1 each cycle wr2arb_req & rd2ram_rd, saturating at 16'hFFFF.
  - cnt_clr=1 forces 0 and overrides the increment that cycle.
- Never assert arb2wr_ack and arb2rd_ack in the same cycle; ack implies en=1.

Decomposition:
- Package pgm_pkg:
  - PGM_ADDR_W=7, PGM_DATA_W=144, PGM_DEPTH=128
  - enum grant_t {GNT_NONE, GNT_RD, GNT_WR}
- Sub-module pgm_arb_rr: 2-way arbiter containing the RR pointer, starvation counter and window-priority logic. It outputs grant_t.
- Top level: the datapath mux, read-valid pipeline register, window register and conflict counter.

Test Plan:
- Reset, then a write alone (addr 7'h05, data 144'hA5…) -> arb2wr_ack and en=1, we=1 in the same cycle. A later read of 7'h05 -> ram2rd_rdata_valid one cycle after arb2rd_ack with data 144'hA5….
- Window closed, both requests held for 6 cycles -> grants alternate RD,WR,RD,WR,RD,WR; conflict_cnt=6.
- start pulse, then read and write held continuously with STARVE_MAX=16 -> reads for 16 cycles, then exactly one write, then reads again. After finish, round-robin resumes.
- start and finish in the same cycle while the window is closed -> window stays closed; a contested grant still follows RR.
- Write and read to addr 7'h10 requested together with pointer favouring read -> read returns old data. The next read returns new data.
- rst_n=0 in the cycle after a read grant -> ram2rd_rdata_valid stays 0; conflict_cnt=0.
- Held requests stall until rst_n=1.
- conflict_cnt driven to 16'hFFFF holds there; cnt_clr -> 0.
